// File: rtl/serial_addsub16_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: default datapath
// width and the sequencer state encoding.
package serial_addsub16_pkg;

    localparam int unsigned ADDSUB_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub16_full_adder.sv
// Single-bit full-adder cell; the only arithmetic in the serial adder/subtractor.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_addsub16.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock, LSB first, through
// a single full-adder cell; result and flags are presented with a done pulse.
module serial_addsub16
    import serial_addsub16_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;
    logic             last_step;

    full_adder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (c),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        res_next  = {fa_sum, result[WIDTH-1:1]};
        last_step = (cnt == LAST_BIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa        <= '0;
            sb        <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b ^ {WIDTH{sub}};
                        c   <= sub;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    result <= res_next;
                    c      <= fa_cout;
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    cnt    <= cnt + 1'b1;
                    // On the MSB step c is the carry into the MSB, so the
                    // signed-overflow flag is formed directly instead of
                    // keeping a separate c_msb register.
                    if (last_step) begin
                        carry_out <= fa_cout;
                        overflow  <= fa_cout ^ c;
                        zero      <= (res_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub16.sv
// Directed self-checking bench for serial_addsub16.
module tb_serial_addsub16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int total;
    int bad;

    logic [15:0] prev_r;
    logic        prev_c;
    logic        prev_v;
    logic        prev_z;

    serial_addsub16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one operation; poke > 0 pulses start with junk operands after that many RUN edges.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic s, input logic [15:0] er, input logic ec,
                          input logic ev, input logic ez, input int poke);
        int n;
        n = 0;
        @(negedge clk);
        a = av; b = bv; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'hA5A5; b = 16'h5A5A; sub = ~s;
        check({tag, ".busy_accept"}, 32'(busy), 32'd1);
        check({tag, ".hold_result"}, 32'(result), 32'(prev_r));
        check({tag, ".hold_flags"}, {29'd0, carry_out, overflow, zero}, {29'd0, prev_c, prev_v, prev_z});
        while (!done && n < 40) begin
            if (poke > 0 && n == poke) begin
                @(negedge clk);
                a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'd16);
        check({tag, ".busy_done"}, 32'(busy), 32'd1);
        check({tag, ".result"}, 32'(result), 32'(er));
        check({tag, ".carry"}, 32'(carry_out), 32'(ec));
        check({tag, ".ovf"}, 32'(overflow), 32'(ev));
        check({tag, ".zero"}, 32'(zero), 32'(ez));
        @(posedge clk); #1;
        check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, ".held"}, {13'd0, result, carry_out, overflow, zero}, {13'd0, er, ec, ev, ez});
        prev_r = er; prev_c = ec; prev_v = ev; prev_z = ez;
    endtask

    initial begin
        int dones;
        total = 0; bad = 0;
        prev_r = '0; prev_c = 1'b0; prev_v = 1'b0; prev_z = 1'b0;
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.ctrl", {30'd0, busy, done}, 32'd0);
        check("reset.out", {13'd0, result, carry_out, overflow, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add3p4",    16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 0);
        run_op("addFFFFp1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
        run_op("add7FFFp1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
        run_op("sub5m7",    16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0);
        run_op("sub8000m1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);

        // Reset in the middle of an operation: start, process 8 bits, then assert reset.
        @(negedge clk);
        a = 16'h1234; b = 16'h0101; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("rst_mid.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.ctrl", {30'd0, busy, done}, 32'd0);
        check("rst_mid.out", {13'd0, result, carry_out, overflow, zero}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("rst_mid.no_done", 32'(dones), 32'd0);
        check("rst_mid.idle", 32'(busy), 32'd0);
        prev_r = '0; prev_c = 1'b0; prev_v = 1'b0; prev_z = 1'b0;

        run_op("add1p1",    16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0);
        run_op("contend",   16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 5);
        run_op("sub0m0",    16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
